// File: rtl/convclk_grayffpf_if.sv
// convclk_grayffpf_if: controller, RAM and consumer signals of the read-side prefetch stage
interface convclk_grayffpf_if #(
  parameter int DATW = 32,
  parameter int BUFD = 4
);
  localparam int CNTW = $clog2(BUFD + 1);
  logic            fifonemp;
  logic            read;
  logic [DATW-1:0] ramdo;
  logic            fiford;
  logic            fifoflush;
  logic            flushout;
  logic [DATW-1:0] dout;
  logic            dvalid;
  logic            dready;
  logic [CNTW-1:0] occ;
  logic            err;
  modport slave (
    input  fifonemp, read, ramdo, fifoflush, dready,
    output fiford, flushout, dout, dvalid, occ, err
  );
  modport master (
    output fifonemp, read, ramdo, fifoflush, dready,
    input  fiford, flushout, dout, dvalid, occ, err
  );
endinterface

// File: rtl/convclk_grayffpf.sv
// convclk_grayffpf: prefetch stage hiding RAM read latency behind a credit-limited valid/ready buffer
module convclk_grayffpf #(
  parameter int DATW  = 32,
  parameter int RDLAT = 2,
  parameter int BUFD  = 4
) (
  input logic               rdclk,
  input logic               rdrst_,
  convclk_grayffpf_if.slave bus
);
  localparam int CNTW = $clog2(BUFD + 1);
  localparam int PTRW = $clog2(BUFD);
  logic [DATW-1:0]  mem_q [BUFD];
  logic [CNTW-1:0]  occ_q, occ_d, inflight;
  logic [PTRW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RDLAT-1:0] pipe_q, pipe_d;
  logic             rstdone_q, err_q, err_d;
  logic             push, pop, full, wr_en;
  function automatic logic [PTRW-1:0] nxt(input logic [PTRW-1:0] p);
    return p == PTRW'(BUFD - 1) ? '0 : p + PTRW'(1);
  endfunction
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) inflight = inflight + CNTW'(pipe_q[i]);
  end
  assign push  = pipe_q[RDLAT-1];
  assign pop   = bus.dvalid & bus.dready;
  assign full  = occ_q == CNTW'(BUFD);
  assign wr_en = push & ~bus.fifoflush & (~full | pop);
  // credit counts words already buffered plus reads still in the RAM pipe
  assign bus.fiford   = rstdone_q & ~bus.fifoflush &
                        (({1'b0, occ_q} + {1'b0, inflight}) < (CNTW + 1)'(BUFD));
  assign bus.flushout = bus.fifoflush;
  assign bus.dvalid   = occ_q != '0;
  assign bus.dout     = mem_q[rptr_q];
  assign bus.occ      = occ_q;
  assign bus.err      = err_q;
  always_comb begin
    pipe_d = bus.fifoflush ? '0 : (pipe_q << 1) | RDLAT'(bus.read);
    wptr_d = bus.fifoflush ? '0 : wr_en ? nxt(wptr_q) : wptr_q;
    rptr_d = bus.fifoflush ? '0 : pop ? nxt(rptr_q) : rptr_q;
    occ_d  = bus.fifoflush ? '0 : occ_q + CNTW'(wr_en) - CNTW'(pop);
    err_d  = err_q | (push & ~bus.fifoflush & ~wr_en);
  end
  always_ff @(posedge rdclk or negedge rdrst_) begin
    if (!rdrst_) begin
      occ_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pipe_q    <= '0;
      rstdone_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < BUFD; i++) mem_q[i] <= '0;
    end else begin
      occ_q     <= occ_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pipe_q    <= pipe_d;
      rstdone_q <= 1'b1;
      err_q     <= err_d;
      if (wr_en) mem_q[wptr_q] <= bus.ramdo;
    end
  end
endmodule

// File: tb/tb_convclk_grayffpf.sv
// tb_convclk_grayffpf: directed scenarios against a controller/RAM model whose data is the read address
module tb_convclk_grayffpf;
  logic rdclk = 1'b0;
  logic rdrst_;
  logic [31:0] rdaddr, a1, a2;
  int total = 0;
  int bad = 0;
  convclk_grayffpf_if #(.DATW(32), .BUFD(4)) bus ();
  convclk_grayffpf #(.DATW(32), .RDLAT(2), .BUFD(4)) dut (
    .rdclk (rdclk),
    .rdrst_(rdrst_),
    .bus   (bus.slave)
  );
  always #5 rdclk = ~rdclk;
  assign bus.read  = bus.fiford & bus.fifonemp;
  assign bus.ramdo = a2;
  always @(posedge rdclk or negedge rdrst_) begin
    if (!rdrst_) begin
      rdaddr <= '0;
      a1     <= '0;
      a2     <= '0;
    end else begin
      rdaddr <= bus.flushout ? 32'd0 : bus.read ? rdaddr + 32'd1 : rdaddr;
      a1     <= rdaddr;
      a2     <= a1;
    end
  end
  task automatic start();
    @(negedge rdclk);
    rdrst_ = 1'b0;
    bus.fifonemp = 1'b0;
    bus.fifoflush = 1'b0;
    repeat (2) @(negedge rdclk);
    rdrst_ = 1'b1;
    repeat (2) @(negedge rdclk);
  endtask
  task automatic test_reset();
    rdrst_ = 1'b0;
    bus.fifonemp = 1'b1;
    bus.fifoflush = 1'b0;
    bus.dready = 1'b1;
    repeat (3) @(negedge rdclk);
    total++;
    if ({bus.dvalid, bus.fiford, bus.err} !== 3'b000 || bus.occ !== 3'd0) begin
      bad++;
      $display("FAIL reset_state dvalid/fiford/err=%b%b%b occ=%0d required 000 occ=0",
               bus.dvalid, bus.fiford, bus.err, bus.occ);
    end
    rdrst_ = 1'b1;
    #1;
    total++;
    if (bus.fiford !== 1'b0) begin bad++; $display("FAIL reset_cycle1 fiford=%b required 0", bus.fiford); end
    @(negedge rdclk);
    #1;
    total++;
    if (bus.fiford !== 1'b1) begin bad++; $display("FAIL reset_cycle2 fiford=%b required 1", bus.fiford); end
  endtask
  task automatic test_stream();
    start();
    bus.dready = 1'b1;
    bus.fifonemp = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge rdclk);
      total++;
      if (bus.dvalid !== 1'b0) begin bad++; $display("FAIL stream_latency cyc=%0d dvalid=%b required 0", i, bus.dvalid); end
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge rdclk);
      total++;
      if (bus.dvalid !== 1'b1 || bus.dout !== 32'(k)) begin
        bad++;
        $display("FAIL stream_word k=%0d dvalid=%b dout=%0d required dvalid=1 dout=%0d", k, bus.dvalid, bus.dout, k);
      end
    end
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("FAIL stream_err err=%b required 0", bus.err); end
  endtask
  task automatic test_backpressure();
    int reads = 0;
    start();
    bus.dready = 1'b0;
    bus.fifonemp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge rdclk);
      #1;
      reads += int'(bus.read);
    end
    total++;
    if (reads !== 4) begin bad++; $display("FAIL bp_reads count=%0d required 4", reads); end
    total++;
    if (bus.occ !== 3'd4 || bus.fiford !== 1'b0) begin
      bad++;
      $display("FAIL bp_full occ=%0d fiford=%b required occ=4 fiford=0", bus.occ, bus.fiford);
    end
    bus.dready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge rdclk);
      #1;
      total++;
      if (bus.dvalid !== 1'b1 || bus.dout !== 32'(k)) begin
        bad++;
        $display("FAIL bp_drain k=%0d dvalid=%b dout=%0d required dvalid=1 dout=%0d", k, bus.dvalid, bus.dout, k);
      end
    end
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("FAIL bp_err err=%b required 0", bus.err); end
  endtask
  task automatic test_bubbles();
    int pat [6] = '{1, 0, 0, 1, 1, 0};
    int nxt = 0;
    logic expv;
    start();
    bus.dready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge rdclk);
      expv = (i >= 3 && i < 9) ? pat[i-3][0] : 1'b0;
      total++;
      if (bus.dvalid !== expv || (expv && bus.dout !== 32'(nxt))) begin
        bad++;
        $display("FAIL bubble i=%0d dvalid=%b dout=%0d required dvalid=%b dout=%0d", i, bus.dvalid, bus.dout, expv, nxt);
      end
      if (expv) nxt++;
      bus.fifonemp = (i < 6) ? pat[i][0] : 1'b0;
    end
    total++;
    if (bus.occ !== 3'd0) begin bad++; $display("FAIL bubble_occ occ=%0d required 0", bus.occ); end
  endtask
  task automatic test_flush();
    int w = 0;
    start();
    bus.dready = 1'b0;
    bus.fifonemp = 1'b1;
    repeat (4) @(negedge rdclk);
    #1;
    total++;
    if (bus.occ !== 3'd2) begin bad++; $display("FAIL flush_pre occ=%0d required 2", bus.occ); end
    bus.fifoflush = 1'b1;
    #1;
    total++;
    if (bus.flushout !== 1'b1 || bus.fiford !== 1'b0) begin
      bad++;
      $display("FAIL flush_pulse flushout=%b fiford=%b required 1 0", bus.flushout, bus.fiford);
    end
    @(negedge rdclk);
    bus.fifoflush = 1'b0;
    #1;
    total++;
    if (bus.occ !== 3'd0 || bus.dvalid !== 1'b0) begin
      bad++;
      $display("FAIL flush_after occ=%0d dvalid=%b required 0 0", bus.occ, bus.dvalid);
    end
    bus.dready = 1'b1;
    while (bus.dvalid !== 1'b1 && w < 10) begin
      @(negedge rdclk);
      w++;
    end
    total++;
    if (bus.dvalid !== 1'b1) begin
      bad++;
      $display("FAIL flush_restart timeout dvalid=%b required 1", bus.dvalid);
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (k > 0) begin @(negedge rdclk); total++; end
        if (bus.dout !== 32'(k) || bus.dvalid !== 1'b1) begin
          bad++;
          $display("FAIL flush_words k=%0d dout=%0d dvalid=%b required dout=%0d dvalid=1", k, bus.dout, bus.dvalid, k);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    start();
    bus.dready = 1'b0;
    bus.fifonemp = 1'b1;
    repeat (5) @(negedge rdclk);
    total++;
    if (bus.occ !== 3'd3) begin bad++; $display("FAIL mid_pre occ=%0d required 3", bus.occ); end
    #2;
    rdrst_ = 1'b0;
    #1;
    total++;
    if (bus.dvalid !== 1'b0 || bus.occ !== 3'd0) begin
      bad++;
      $display("FAIL mid_async dvalid=%b occ=%0d required 0 0", bus.dvalid, bus.occ);
    end
    @(negedge rdclk);
    rdrst_ = 1'b1;
    #1;
    total++;
    if (bus.fiford !== 1'b0) begin bad++; $display("FAIL mid_cycle1 fiford=%b required 0", bus.fiford); end
    @(negedge rdclk);
    #1;
    total++;
    if (bus.fiford !== 1'b1 || bus.dvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_cycle2 fiford=%b dvalid=%b required 1 0", bus.fiford, bus.dvalid);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
